// File: rtl/ah_snoop_pkg.sv
// Shared definitions for the snoop-then-push controller: state encoding
// and default parameter values.
package ah_snoop_pkg;

    localparam int AH_DW_DEFAULT    = 10;
    localparam int AH_CNT_W_DEFAULT = 16;

    typedef logic [1:0] ah_state_t;

    localparam ah_state_t ST_IDLE  = 2'd0;
    localparam ah_state_t ST_SNOOP = 2'd1;
    localparam ah_state_t ST_PUSH  = 2'd2;

endpackage : ah_snoop_pkg

// File: rtl/ah_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module ah_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    // Count increment requests, holding at the maximum value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= {W{1'b0}};
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign cnt = r_cnt;

endmodule : ah_sat_counter

// File: rtl/ah_snoop_push_ctrl.sv
// Snoop-then-push controller: each accepted item is looked up in a
// snoopable FIFO; duplicates are dropped, unique items are written.
// Optional drop statistics counter enabled by AH_SNOOP_PUSH_STATS_EN.
module ah_snoop_push_ctrl
    import ah_snoop_pkg::*;
#(
    parameter int DW    = AH_DW_DEFAULT,
    parameter int CNT_W = AH_CNT_W_DEFAULT
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] sdata,
    output logic          svalid,
    input  logic          smatch,
    output logic [DW-1:0] wdata,
    output logic          wvalid,
    input  logic          wready,
    output logic          busy
`ifdef AH_SNOOP_PUSH_STATS_EN
    ,
    output logic [CNT_W-1:0] drop_cnt
`endif
);

    ah_state_t     r_state;
    ah_state_t     w_state_nxt;
    logic [DW-1:0] r_hold;
    logic          r_svalid;
    logic          r_wvalid;
    logic          r_in_ready;
    logic          r_busy;
    logic          w_accept;

    assign w_accept = (r_state == ST_IDLE) && in_valid;

    // Next-state decode; smatch/wready only matter in their own state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_SNOOP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SNOOP: begin
                if (smatch) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (wready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_PUSH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus output flags registered from the next state so
    // the handshake outputs come straight from flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_svalid   <= 1'b0;
            r_wvalid   <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_svalid   <= (w_state_nxt == ST_SNOOP);
            r_wvalid   <= (w_state_nxt == ST_PUSH);
            r_in_ready <= (w_state_nxt == ST_IDLE);
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    // Capture the upstream item when it is accepted in IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hold <= {DW{1'b0}};
        end else if (w_accept) begin
            r_hold <= in_data;
        end else begin
            r_hold <= r_hold;
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign svalid   = r_svalid;
    assign wvalid   = r_wvalid;
    assign sdata    = r_hold;
    assign wdata    = r_hold;

`ifdef AH_SNOOP_PUSH_STATS_EN
    logic w_drop;

    assign w_drop = (r_state == ST_SNOOP) && smatch;

    ah_sat_counter #(
        .W (CNT_W)
    ) u_drop_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (w_drop),
        .cnt  (drop_cnt)
    );
`else
    // No drop statistics in this build.
`endif

endmodule : ah_snoop_push_ctrl

// File: tb/tb_ah_snoop_push_ctrl.sv
// Self-checking bench for ah_snoop_push_ctrl: directed scenarios plus
// randomized items, checked against an expected-write list with timing.
module tb_ah_snoop_push_ctrl;

    localparam int DW = 10;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] sdata;
    logic          svalid;
    logic          smatch;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic          busy;
`ifdef AH_SNOOP_PUSH_STATS_EN
    logic [CW-1:0] drop_cnt;
`endif

    ah_snoop_push_ctrl #(
        .DW    (DW),
        .CNT_W (CW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sdata    (sdata),
        .svalid   (svalid),
        .smatch   (smatch),
        .wdata    (wdata),
        .wvalid   (wvalid),
        .wready   (wready),
        .busy     (busy)
`ifdef AH_SNOOP_PUSH_STATS_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc_n;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  drops   = 0;

    // Cycle counter and write monitor: every accepted FIFO write is logged.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rstn && wvalid && wready) begin
            obs_q.push_back('{data: wdata, cyc_n: cyc});
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_drops();
`ifdef AH_SNOOP_PUSH_STATS_EN
        int sat;
        sat = (drops > 3) ? 3 : drops;
        check_val("drop_cnt", 32'(drop_cnt), 32'(sat));
`endif
    endtask

    // One item from IDLE through snoop and either drop or push.
    task automatic do_item(input logic [DW-1:0] d, input bit m, input int stall, input bit noise);
        int ca;
        check_val("idle_in_ready", 32'(in_ready), 32'd1);
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("idle_svalid", 32'(svalid), 32'd0);
        check_val("idle_wvalid", 32'(wvalid), 32'd0);
        in_valid = 1'b1;
        in_data  = d;
        smatch   = 1'($urandom);
        wready   = 1'($urandom);
        ca       = cyc;
        step();
        check_val("snoop_svalid", 32'(svalid), 32'd1);
        check_val("snoop_sdata", 32'(sdata), 32'(d));
        check_val("snoop_wvalid", 32'(wvalid), 32'd0);
        check_val("snoop_in_ready", 32'(in_ready), 32'd0);
        check_val("snoop_busy", 32'(busy), 32'd1);
        in_valid = (noise && !m) ? 1'($urandom) : 1'b0;
        in_data  = DW'($urandom);
        smatch   = m;
        wready   = 1'($urandom);
        step();
        if (m) begin
            drops++;
            check_val("drop_wvalid", 32'(wvalid), 32'd0);
            check_val("drop_svalid", 32'(svalid), 32'd0);
            check_val("drop_in_ready", 32'(in_ready), 32'd1);
            check_drops();
        end else begin
            exp_q.push_back('{data: d, cyc_n: ca + 2 + stall});
            for (int i = 0; i <= stall; i++) begin
                check_val("push_wvalid", 32'(wvalid), 32'd1);
                check_val("push_wdata", 32'(wdata), 32'(d));
                check_val("push_svalid", 32'(svalid), 32'd0);
                check_val("push_in_ready", 32'(in_ready), 32'd0);
                check_val("push_busy", 32'(busy), 32'd1);
                wready   = (i == stall);
                smatch   = 1'($urandom);
                in_valid = (noise && i != stall) ? 1'($urandom) : 1'b0;
                in_data  = DW'($urandom);
                step();
            end
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            check_val("gap_in_ready", 32'(in_ready), 32'd1);
            check_val("gap_wvalid", 32'(wvalid), 32'd0);
            in_valid = 1'b0;
            in_data  = DW'($urandom);
            smatch   = 1'($urandom);
            wready   = 1'($urandom);
            step();
        end
    endtask

    initial begin
        rstn     = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        smatch   = 1'b0;
        wready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_svalid", 32'(svalid), 32'd0);
        check_val("rst_wvalid", 32'(wvalid), 32'd0);
        check_drops();
        rstn = 1'b1;
        step();
        check_val("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Unique push, duplicate drop, backpressure.
        do_item(10'h155, 1'b0, 0, 1'b0);
        do_item(10'h0AA, 1'b1, 0, 1'b0);
        gap(1);
        do_item(10'h3C3, 1'b0, 5, 1'b0);

        // Reset while stalled in PUSH: the held item must never be written.
        in_valid = 1'b1;
        in_data  = 10'h2E7;
        step();
        in_valid = 1'b0;
        smatch   = 1'b0;
        wready   = 1'b0;
        step();
        check_val("rstpush_wvalid_pre", 32'(wvalid), 32'd1);
        step();
        rstn = 1'b0;
        #1;
        check_val("rstpush_wvalid", 32'(wvalid), 32'd0);
        check_val("rstpush_busy", 32'(busy), 32'd0);
        drops = 0;
        check_drops();
        @(posedge clk);
        #1;
        rstn   = 1'b1;
        wready = 1'b1;
        step();
        check_val("rstpush_in_ready", 32'(in_ready), 32'd1);
        check_val("rstpush_no_write", 32'(wvalid), 32'd0);
        gap(2);

        // Five duplicates in a row: counter saturates.
        for (int i = 0; i < 5; i++) begin
            do_item(DW'(i + 1), 1'b1, 0, 1'b0);
        end

        // Back-to-back with in_valid noise: alternating unique/duplicate.
        for (int i = 0; i < 4; i++) begin
            do_item(DW'(10'h100 + i), (i % 2) == 1, 0, 1'b1);
        end

        // Randomized items.
        for (int i = 0; i < 60; i++) begin
            do_item(DW'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b1);
            gap(int'($urandom_range(0, 2)));
        end

        gap(2);
        check_val("write_count", 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e;
            wr_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check_val("write_data", 32'(o.data), 32'(e.data));
            check_val("write_cycle", 32'(o.cyc_n), 32'(e.cyc_n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ah_snoop_push_ctrl
